// File: rtl/seq_subtractor_16bit.sv
// -----------------------------------------------------------------------------
// seq_subtractor_16bit
//
// Multi-cycle unsigned subtractor: {bout,diff} = a - b - bin, evaluated DIGIT
// bits per clock from LSB to MSB with a single DIGIT-wide subtract slice.
//
// Parameters
//   WIDTH  operand/result width (default 16)
//   DIGIT  bits processed per clock; must divide WIDTH exactly
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted in IDLE or DONE
//   a      in   minuend, sampled with accepted start
//   b      in   subtrahend, sampled with accepted start
//   bin    in   borrow-in, sampled with accepted start
//   busy   out  high while in RUN
//   done   out  one-cycle pulse, diff/bout just updated
//   diff   out  registered difference, held until next completion
//   bout   out  registered borrow-out, held until next completion
//   ovf    out  signed overflow (only with SEQ_SUB_OVERFLOW_EN defined)
//
// Build option
//   SEQ_SUB_OVERFLOW_EN  adds the registered ovf output
//
// State table
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one DIGIT slice subtracted per clock
//   DONE  | result just loaded, done pulse; start here chains a new op
// -----------------------------------------------------------------------------
module seq_subtractor_16bit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SEQ_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_subtractor_16bit: DIGIT must divide WIDTH exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] shadow;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] shadow_nxt;

`ifdef SEQ_SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: one DIGIT slice per clock
  // ---------------------------------------------------------------------------
  // The top bit of the (DIGIT+1)-bit result is the borrow out of this slice.
  assign slice = {1'b0, a_sh[DIGIT-1:0]}
               - {1'b0, b_sh[DIGIT-1:0]}
               - {{DIGIT{1'b0}}, borrow};

  // New slice enters at the top; after N shifts slice 0 sits at the LSB.
  // Written as a shift of the concatenation so DIGIT==WIDTH needs no
  // special case.
  assign shadow_nxt = WIDTH'({slice[DIGIT-1:0], shadow} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      shadow <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      shadow <= shadow_nxt;
      borrow <= slice[DIGIT];
      cnt    <= cnt + CW'(1);
      if (last) begin
        diff <= shadow_nxt;
        bout <= slice[DIGIT];
      end
    end
  end

`ifdef SEQ_SUB_OVERFLOW_EN
  // Operand sign bits are kept separately because a_sh/b_sh shift away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (last) begin
      ovf <= (a_msb != b_msb) && (shadow_nxt[WIDTH-1] != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_seq_subtractor_16bit.sv
module tb_seq_subtractor_16bit;

  logic        clk;
  logic        rst_n;
  logic        start4, start1, start16;
  logic [15:0] a_i, b_i;
  logic        bin_i;

  logic        busy4, done4, bout4;
  logic [15:0] diff4;
  logic        busy1, done1, bout1;
  logic [15:0] diff1;
  logic        busy16, done16, bout16;
  logic [15:0] diff16;
`ifdef SEQ_SUB_OVERFLOW_EN
  logic        ovf4, ovf1, ovf16;
`endif

  int nvec = 0;
  int nerr = 0;

  seq_subtractor_16bit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a_i), .b(b_i), .bin(bin_i),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SEQ_SUB_OVERFLOW_EN
    , .ovf(ovf4)
`endif
  );

  seq_subtractor_16bit #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a_i), .b(b_i), .bin(bin_i),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SEQ_SUB_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  seq_subtractor_16bit #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a_i), .b(b_i), .bin(bin_i),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
`ifdef SEQ_SUB_OVERFLOW_EN
    , .ovf(ovf16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation into the selected instance (4, 1 or 16) and wait
  // for its done pulse. lat = negedges after the accepting edge (-1 on timeout).
  task automatic do_op(input int which, input logic [15:0] av, input logic [15:0] bv,
                       input logic binv, output int lat);
    logic d;
    @(negedge clk);
    a_i = av; b_i = bv; bin_i = binv;
    if (which == 4) start4 = 1'b1;
    else if (which == 1) start1 = 1'b1;
    else start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      d = (which == 4) ? done4 : (which == 1) ? done1 : done16;
      if (d) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    nvec++; if (busy4 !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    nvec++; if (done4 !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", done4); end
    nvec++; if (diff4 !== 16'h0000) begin nerr++; $display("FAIL reset_diff got=%h exp=0000", diff4); end
    nvec++; if (bout4 !== 1'b0) begin nerr++; $display("FAIL reset_bout got=%b exp=0", bout4); end
`ifdef SEQ_SUB_OVERFLOW_EN
    nvec++; if (ovf4 !== 1'b0) begin nerr++; $display("FAIL reset_ovf got=%b exp=0", ovf4); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    @(negedge clk);
    a_i = 16'h1234; b_i = 16'h0034; bin_i = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      nvec++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin
        nerr++; $display("FAIL basic_run cyc=%0d busy=%b done=%b exp busy=1 done=0", i, busy4, done4);
      end
      @(negedge clk);
    end
    nvec++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin
      nerr++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done4, busy4);
    end
    nvec++; if (diff4 !== 16'h1200 || bout4 !== 1'b0) begin
      nerr++; $display("FAIL basic_result got=%h/%b exp=1200/0", diff4, bout4);
    end
    @(negedge clk);
    nvec++; if (done4 !== 1'b0) begin nerr++; $display("FAIL basic_done_width got=%b exp=0", done4); end
  endtask

  task automatic test_borrow();
    int lat;
    do_op(4, 16'h0000, 16'h0001, 1'b0, lat);
    nvec++; if (lat != 4 || diff4 !== 16'hFFFF || bout4 !== 1'b1) begin
      nerr++; $display("FAIL borrow_0m1 got lat=%0d %h/%b exp lat=4 FFFF/1", lat, diff4, bout4);
    end
    do_op(4, 16'h0005, 16'h0005, 1'b1, lat);
    nvec++; if (lat != 4 || diff4 !== 16'hFFFF || bout4 !== 1'b1) begin
      nerr++; $display("FAIL borrow_bin got lat=%0d %h/%b exp lat=4 FFFF/1", lat, diff4, bout4);
    end
    do_op(4, 16'hF00D, 16'h1234, 1'b1, lat);
    nvec++; if (diff4 !== 16'hDDD8 || bout4 !== 1'b0) begin
      nerr++; $display("FAIL borrow_mix got=%h/%b exp=DDD8/0", diff4, bout4);
    end
  endtask

`ifdef SEQ_SUB_OVERFLOW_EN
  task automatic test_ovf();
    int lat;
    do_op(4, 16'h8000, 16'h0001, 1'b1, lat);
    nvec++; if (diff4 !== 16'h7FFE || bout4 !== 1'b0 || ovf4 !== 1'b1) begin
      nerr++; $display("FAIL ovf_set got=%h/%b/%b exp=7FFE/0/1", diff4, bout4, ovf4);
    end
    do_op(4, 16'h7FFF, 16'h0001, 1'b0, lat);
    nvec++; if (diff4 !== 16'h7FFE || ovf4 !== 1'b0) begin
      nerr++; $display("FAIL ovf_clr got=%h/%b exp=7FFE/0", diff4, ovf4);
    end
  endtask
`endif

  task automatic test_ignore_start();
    int lat;
    int ndone;
    do_op(4, 16'h00FF, 16'h0000, 1'b0, lat);
    @(negedge clk);
    a_i = 16'h0010; b_i = 16'h0001; bin_i = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_i = 16'hFFFF; b_i = 16'h0000; start4 = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) start4 = 1'b0;
      if (i < 4) begin
        nvec++; if (diff4 !== 16'h00FF) begin
          nerr++; $display("FAIL ignore_hold cyc=%0d got=%h exp=00FF", i, diff4);
        end
      end
      if (done4) ndone++;
      @(negedge clk);
    end
    nvec++; if (ndone != 1) begin nerr++; $display("FAIL ignore_pulses got=%0d exp=1", ndone); end
    nvec++; if (diff4 !== 16'h000F || bout4 !== 1'b0) begin
      nerr++; $display("FAIL ignore_result got=%h/%b exp=000F/0", diff4, bout4);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int ndone;
    @(negedge clk);
    a_i = 16'h1111; b_i = 16'h0001; bin_i = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 16'h0000 || bout4 !== 1'b0) begin
      nerr++; $display("FAIL midreset got busy=%b done=%b diff=%h bout=%b exp 0/0/0000/0",
                       busy4, done4, diff4, bout4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    nvec++; if (ndone != 0) begin nerr++; $display("FAIL midreset_nodone got=%0d exp=0", ndone); end
    do_op(4, 16'h0003, 16'h0001, 1'b0, lat);
    nvec++; if (lat != 4 || diff4 !== 16'h0002 || bout4 !== 1'b0) begin
      nerr++; $display("FAIL midreset_after got lat=%0d %h/%b exp lat=4 0002/0", lat, diff4, bout4);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(4, 16'h0020, 16'h0001, 1'b0, lat);
    nvec++; if (diff4 !== 16'h001F) begin nerr++; $display("FAIL b2b_first got=%h exp=001F", diff4); end
    a_i = 16'h0100; b_i = 16'h0001; bin_i = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    nvec++; if (busy4 !== 1'b1) begin nerr++; $display("FAIL b2b_busy got=%b exp=1", busy4); end
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done4) begin lat = i; break; end
      @(negedge clk);
    end
    nvec++; if (lat != 4 || diff4 !== 16'h00FF || bout4 !== 1'b0) begin
      nerr++; $display("FAIL b2b_second got lat=%0d %h/%b exp lat=4 00FF/0", lat, diff4, bout4);
    end
  endtask

  task automatic test_digit_variants();
    int lat;
    do_op(1, 16'h1234, 16'h4321, 1'b0, lat);
    nvec++; if (lat != 16 || diff1 !== 16'hCF13 || bout1 !== 1'b1) begin
      nerr++; $display("FAIL digit1 got lat=%0d %h/%b exp lat=16 CF13/1", lat, diff1, bout1);
    end
    do_op(16, 16'hABCD, 16'h0BCE, 1'b1, lat);
    nvec++; if (lat != 1 || diff16 !== 16'h9FFE || bout16 !== 1'b0) begin
      nerr++; $display("FAIL digit16 got lat=%0d %h/%b exp lat=1 9FFE/0", lat, diff16, bout16);
    end
    do_op(16, 16'h0000, 16'hFFFF, 1'b1, lat);
    nvec++; if (lat != 1 || diff16 !== 16'h0000 || bout16 !== 1'b1) begin
      nerr++; $display("FAIL digit16_wrap got lat=%0d %h/%b exp lat=1 0000/1", lat, diff16, bout16);
    end
  endtask

  initial begin
    start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    a_i = '0; b_i = '0; bin_i = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
`ifdef SEQ_SUB_OVERFLOW_EN
    test_ovf();
`endif
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_digit_variants();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
